madd_sequencer: RTL and testbench
=================================

# madd_sequencer

Controller that sequences the shared 16-bit fixed-point multiply-add datapath (out = x·w + b) through an N-element dot product plus bias, y = b + Σ x[i]·w[i]. This is the per-gate pre-activation step of the GRU/LSTM cells. It accepts operand pairs over a valid/ready stream and feeds the running accumulator back into the datapath's b input. It returns the result over a valid/ready output. The multiply-add datapath sits outside this block; the sequencer drives its operands combinationally and samples its result.

## Interface
- DATA_WIDTH, 16: operand, accumulator and result width (signed, two's complement).
- FRACT_WIDTH, 8: fractional bits (Q8.8 by default). Not used by the sequencer; passed to the datapath instance alongside it.
- LEN_WIDTH, 8: width of the element-count field.

- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  reset. Synchronous and active-high.
- start  input  1  begin a job. Honoured only in IDLE.
- len  input  LEN_WIDTH  number of operand pairs. Sampled with start.
- bias  input  DATA_WIDTH  initial accumulator value. Sampled with start.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer accepts a pair. High only in RUN.
- in_x, in_w  input  DATA_WIDTH each  operand pair.
- madd_x, madd_w  output  DATA_WIDTH each  to datapath. Combinational copies of in_x and in_w.
- madd_b  output  DATA_WIDTH  to datapath. Equals the acc register.
- madd_out  input  DATA_WIDTH  datapath result. Combinational, valid in the same cycle.
- out_valid  output  1  result valid. High only in DONE.
- out_data  output  DATA_WIDTH  result. Equals acc.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, DONE. State is encoded in registers; all outputs are decoded from state and registers.
- IDLE:
  - If start=1: acc <= bias and cnt <= len.
  - If len≠0, go to RUN. If len=0, go to DONE.
- RUN:
  - in_ready=1.
  - On a handshake (in_valid & in_ready): acc <= madd_out and cnt <= cnt−1.
  - If cnt=1 at the handshake, go to DONE.
  - Cycles with in_valid=0 leave acc, cnt and state unchanged.
- DONE:
  - out_valid=1 and out_data=acc.
  - On out_ready=1, go to IDLE. Otherwise hold with all outputs stable.
- Arithmetic belongs to the datapath: trunc((x·w) >>> FRACT_WIDTH) + b, wrapping modulo 2^DATA_WIDTH. The sequencer never saturates and never modifies madd_out.
- start outside IDLE is ignored. len and bias are not re-sampled mid-job.
- in_valid outside RUN is ignored, because in_ready=0. No pair is consumed.
- Back-to-back jobs: start may be asserted in the first IDLE cycle after DONE completes. There is no bubble requirement beyond that single IDLE cycle.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, busy=0, out_data=0, madd_b=0.
- rst=1 in any state, including mid-RUN or DONE with out_valid high, returns to IDLE on the next edge. No partial result is emitted.
- Latency, start sampled at edge 0 with in_valid held high:
  - Pairs are accepted at edges 1..N.
  - out_valid is high in the cycle after edge N.
  - That is N+1 cycles from start to out_valid.
- With len=0, out_valid is high in the cycle after the start edge, with out_data=bias.
- Throughput: one pair per cycle in RUN. There is no combinational path from out_ready to in_ready.
- madd_x, madd_w and madd_b are stable whenever in_valid & in_ready is high.
- cnt reload: len is 1..2^LEN_WIDTH−1. The value 0 is handled as above and never wraps.

## Test plan
- Basic job, Q8.8: bias=0x0080, len=3, three pairs of x=0x0100 and w=0x0200, in_valid held high, out_ready=1. Required: out_valid 4 cycles after start, out_data=0x0680, then IDLE with busy=0.
- Sign and stalls: bias=0x0000, len=2, pairs (0xFF00, 0x0100) and (0x0200, 0x0080), with two idle in_valid=0 cycles between them. Required: pairs accepted only on valid cycles, out_data=0x0000 (−1.0 + 1.0).
- Zero length: start with len=0 and bias=0x1234. Required: out_valid next cycle, out_data=0x1234, in_ready never high.
- Output backpressure: after a len=1 job (0x0100 × 0x0100, bias 0), hold out_ready=0 for 5 cycles. Required: out_valid and out_data=0x0100 stable throughout. Assert start during this time; it is ignored. IDLE is entered one cycle after out_ready=1.
- Reset mid-RUN: len=4, assert rst after 2 pairs accepted. Required: next cycle state IDLE, acc=0, in_ready=0, out_valid=0. A new len=1 job then produces the correct result from its own bias.
- Wrap-around: bias=0x7F00, len=1, pair 0x0200 × 0x0100. Required: out_data=0x8100, a wrapped result with no saturation.

Source files
------------

// File: rtl/madd_sequencer_if.sv
// Stream and datapath bundle for madd_sequencer. The slave modport is the sequencer's view.
// The master modport is the view of the environment that drives jobs and hosts the datapath.
interface madd_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 8
);
   logic                  start;
   logic [LEN_WIDTH-1:0]  len;
   logic [DATA_WIDTH-1:0] bias;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_x;
   logic [DATA_WIDTH-1:0] in_w;
   logic [DATA_WIDTH-1:0] madd_x;
   logic [DATA_WIDTH-1:0] madd_w;
   logic [DATA_WIDTH-1:0] madd_b;
   logic [DATA_WIDTH-1:0] madd_out;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   logic                  busy;

   modport master (
      output start, len, bias, in_valid, in_x, in_w, madd_out, out_ready,
      input  in_ready, madd_x, madd_w, madd_b, out_valid, out_data, busy
   );

   modport slave (
      input  start, len, bias, in_valid, in_x, in_w, madd_out, out_ready,
      output in_ready, madd_x, madd_w, madd_b, out_valid, out_data, busy
   );
endinterface

// File: rtl/madd_sequencer.sv
// madd_sequencer: steps an external multiply-add datapath through y = b + sum(x[i] * w[i]).
// The accumulator is fed back as the datapath's b operand; each accepted pair latches its result.
// The fixed-point scaling lives entirely in the datapath, so no fractional width is needed here.
module madd_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 8
) (
   input logic             clk,
   input logic             rst,
   madd_sequencer_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [DATA_WIDTH-1:0] w_acc_nxt;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic [LEN_WIDTH-1:0]  w_cnt_nxt;
   logic                  w_in_hs;

   assign w_in_hs = bus.in_valid & (r_state == S_RUN);

   // Next-state, accumulator and remaining-pair count.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_acc_nxt   = bus.bias;
               w_cnt_nxt   = bus.len;
               // A zero-length job is just the bias; skip RUN so cnt never wraps.
               w_state_nxt = (bus.len != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (w_in_hs) begin
               w_acc_nxt = bus.madd_out;
               w_cnt_nxt = r_cnt - LEN_WIDTH'(1);
               if (r_cnt == LEN_WIDTH'(1)) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Outputs decode from registered state only, so out_ready never reaches in_ready.
   always_comb begin
      bus.in_ready  = (r_state == S_RUN);
      bus.out_valid = (r_state == S_DONE);
      bus.busy      = (r_state != S_IDLE);
      bus.out_data  = r_acc;
      bus.madd_b    = r_acc;
      bus.madd_x    = bus.in_x;
      bus.madd_w    = bus.in_w;
   end
endmodule

// File: tb/tb_madd_sequencer.sv
// Self-checking bench for madd_sequencer. The datapath is modelled here. Expected results are
// computed as bias plus the sum of per-pair Q8.8 products, independent of the sequencer's FSM.
module tb_madd_sequencer;
   localparam int DW = 16;
   localparam int LW = 8;
   localparam int FW = 8;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [DW-1:0] job_x [256];
   logic [DW-1:0] job_w [256];

   madd_sequencer_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   madd_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One multiply-add step: trunc((x*w) >>> FW) + b, modulo 2^DW.
   function automatic logic [DW-1:0] ref_madd(input logic [DW-1:0] x, input logic [DW-1:0] w,
                                              input logic [DW-1:0] b);
      logic signed [2*DW-1:0] p;
      p = $signed(x) * $signed(w);
      p = p >>> FW;
      return p[DW-1:0] + b;
   endfunction

   assign bus.madd_out = ref_madd(bus.madd_x, bus.madd_w, bus.madd_b);

   // Runs one job from IDLE until out_valid (or a cycle budget) and reports what was seen.
   // cyc counts edges after the start edge until out_valid is visible.
   task automatic do_job(input logic [DW-1:0] b, input int n, input int stall_pct,
                         output int cyc, output int acc_cnt, output logic vld,
                         output logic [DW-1:0] res, output logic [DW-1:0] exp,
                         output int path_err);
      logic [DW-1:0] racc;
      logic          hs;
      int            guard;
      exp = b;
      for (int i = 0; i < n; i++) exp = ref_madd(job_x[i], job_w[i], exp);
      racc     = b;
      path_err = 0;
      acc_cnt  = 0;
      cyc      = 0;
      guard    = 0;
      bus.start = 1'b1;
      bus.len   = LW'(n);
      bus.bias  = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (bus.out_valid !== 1'b1 && guard < 2000) begin
         if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) path_err++;
         bus.in_valid = (acc_cnt < n) && (int'($urandom_range(99)) >= stall_pct);
         bus.in_x     = (acc_cnt < n) ? job_x[acc_cnt] : DW'($urandom);
         bus.in_w     = (acc_cnt < n) ? job_w[acc_cnt] : DW'($urandom);
         #1;
         if (bus.madd_x !== bus.in_x || bus.madd_w !== bus.in_w || bus.madd_b !== racc)
            path_err++;
         hs = bus.in_valid & bus.in_ready;
         @(posedge clk); #1;
         cyc++;
         guard++;
         if (hs) begin
            racc = ref_madd(bus.in_x, bus.in_w, racc);
            acc_cnt++;
         end
         bus.in_valid = 1'b0;
      end
      vld = bus.out_valid;
      res = bus.out_data;
      if (bus.in_ready !== 1'b0) path_err++;
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.start    = 1'b1;
      bus.len      = 8'd5;
      bus.bias     = 16'h5555;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: busy/in_ready/out_valid=%b%b%b want 000",
                  bus.busy, bus.in_ready, bus.out_valid);
      end
      total++;
      if (bus.out_data !== 16'h0000 || bus.madd_b !== 16'h0000) begin
         bad++;
         $display("FAIL reset_acc: out_data=%h madd_b=%h want 0000", bus.out_data, bus.madd_b);
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      rst          = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int cyc, acc_cnt, perr;
      logic vld;
      logic [DW-1:0] res, exp;
      for (int i = 0; i < 3; i++) begin
         job_x[i] = 16'h0100;
         job_w[i] = 16'h0200;
      end
      do_job(16'h0080, 3, 0, cyc, acc_cnt, vld, res, exp, perr);
      total++;
      if (vld !== 1'b1 || res !== 16'h0680) begin
         bad++;
         $display("FAIL basic_result: valid=%b data=%h want 1 0680", vld, res);
      end
      total++;
      // Start at edge 0, pairs at edges 1..3, out_valid visible after edge 3.
      if (cyc != 3) begin
         bad++;
         $display("FAIL basic_latency: edges=%0d want 3", cyc);
      end
      total++;
      if (perr != 0 || acc_cnt != 3) begin
         bad++;
         $display("FAIL basic_path: path_err=%0d accepted=%0d want 0 3", perr, acc_cnt);
      end
      release_result();
      total++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_idle: busy=%b out_valid=%b want 0 0", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_sign_stalls();
      int errs;
      errs = 0;
      bus.start = 1'b1;
      bus.len   = 8'd2;
      bus.bias  = 16'h0000;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_x     = 16'hFF00;
      bus.in_w     = 16'h0100;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_x = DW'($urandom);
         bus.in_w = DW'($urandom);
         @(posedge clk); #1;
         if (bus.madd_b !== 16'hFF00 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL stall_hold: %0d stall cycles moved acc/state, want 0", errs);
      end
      bus.in_valid = 1'b1;
      bus.in_x     = 16'h0200;
      bus.in_w     = 16'h0080;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000) begin
         bad++;
         $display("FAIL sign_result: valid=%b data=%h want 1 0000", bus.out_valid, bus.out_data);
      end
      release_result();
   endtask

   task automatic test_zero_len();
      int cyc, acc_cnt, perr;
      logic vld;
      logic [DW-1:0] res, exp;
      do_job(16'h1234, 0, 0, cyc, acc_cnt, vld, res, exp, perr);
      total++;
      if (vld !== 1'b1 || res !== 16'h1234 || cyc != 0) begin
         bad++;
         $display("FAIL zero_len: valid=%b data=%h edges=%0d want 1 1234 0", vld, res, cyc);
      end
      total++;
      if (perr != 0) begin
         bad++;
         $display("FAIL zero_len_ready: path_err=%0d want 0", perr);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int cyc, acc_cnt, perr, errs;
      logic vld;
      logic [DW-1:0] res, exp;
      job_x[0] = 16'h0100;
      job_w[0] = 16'h0100;
      do_job(16'h0000, 1, 0, cyc, acc_cnt, vld, res, exp, perr);
      total++;
      if (vld !== 1'b1 || res !== 16'h0100) begin
         bad++;
         $display("FAIL bp_result: valid=%b data=%h want 1 0100", vld, res);
      end
      errs = 0;
      bus.start = 1'b1;
      bus.len   = 8'd3;
      bus.bias  = 16'h7777;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0100 || bus.in_ready !== 1'b0) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL bp_stable: %0d unstable cycles under backpressure, want 0", errs);
      end
      bus.start = 1'b0;
      release_result();
      total++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_idle: busy=%b out_valid=%b want 0 0", bus.busy, bus.out_valid);
      end
      @(posedge clk); #1;
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_start_ignored: busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int cyc, acc_cnt, perr;
      logic vld;
      logic [DW-1:0] res, exp, b;
      bus.start = 1'b1;
      bus.len   = 8'd4;
      bus.bias  = 16'h0300;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_x     = 16'h0100;
      bus.in_w     = 16'h0100;
      repeat (2) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.madd_b !== 16'h0000) begin
         bad++;
         $display("FAIL rst_mid_run: busy=%b in_ready=%b out_valid=%b acc=%h want 0 0 0 0000",
                  bus.busy, bus.in_ready, bus.out_valid, bus.madd_b);
      end
      b        = DW'($urandom);
      job_x[0] = DW'($urandom);
      job_w[0] = DW'($urandom);
      do_job(b, 1, 0, cyc, acc_cnt, vld, res, exp, perr);
      total++;
      if (vld !== 1'b1 || res !== exp || perr != 0) begin
         bad++;
         $display("FAIL rst_new_job: valid=%b data=%h path_err=%0d want 1 %h 0",
                  vld, res, perr, exp);
      end
      release_result();
   endtask

   task automatic test_wrap();
      int cyc, acc_cnt, perr;
      logic vld;
      logic [DW-1:0] res, exp;
      job_x[0] = 16'h0200;
      job_w[0] = 16'h0100;
      do_job(16'h7F00, 1, 0, cyc, acc_cnt, vld, res, exp, perr);
      total++;
      if (vld !== 1'b1 || res !== 16'h8100) begin
         bad++;
         $display("FAIL wrap: valid=%b data=%h want 1 8100", vld, res);
      end
      release_result();
   endtask

   task automatic test_max_len();
      int cyc, acc_cnt, perr;
      logic vld;
      logic [DW-1:0] res, exp;
      for (int i = 0; i < 255; i++) begin
         job_x[i] = DW'($urandom);
         job_w[i] = DW'($urandom);
      end
      do_job(DW'($urandom), 255, 0, cyc, acc_cnt, vld, res, exp, perr);
      total++;
      if (vld !== 1'b1 || res !== exp || cyc != 255 || acc_cnt != 255 || perr != 0) begin
         bad++;
         $display("FAIL max_len: valid=%b data=%h edges=%0d acc=%0d perr=%0d want 1 %h 255 255 0",
                  vld, res, cyc, acc_cnt, perr, exp);
      end
      release_result();
   endtask

   task automatic test_back_to_back();
      int cyc, acc_cnt, perr, n;
      logic vld;
      logic [DW-1:0] res, exp;
      for (int j = 0; j < 8; j++) begin
         n = (j == 3) ? 0 : int'($urandom_range(16, 1));
         for (int i = 0; i < n; i++) begin
            job_x[i] = DW'($urandom);
            job_w[i] = DW'($urandom);
         end
         do_job(DW'($urandom), n, 30, cyc, acc_cnt, vld, res, exp, perr);
         total++;
         if (vld !== 1'b1 || res !== exp || acc_cnt != n || perr != 0) begin
            bad++;
            $display("FAIL b2b_job%0d: valid=%b data=%h acc=%0d perr=%0d want 1 %h %0d 0",
                     j, vld, res, acc_cnt, perr, exp, n);
         end
         release_result();
         total++;
         if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle%0d: busy=%b want 0", j, bus.busy);
         end
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.bias      = '0;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_w      = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_sign_stalls();
      test_zero_len();
      test_backpressure();
      test_reset_mid_run();
      test_wrap();
      test_max_len();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
